regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, data width of register writeback.
REQ-002 Parameter: REG_ID_W, default 5, register index width; 2**REG_ID_W registers, x0 hardwired zero.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 aluValid_i  input  1  ALU requester has a writeback pending.
REQ-006 aluRdId_i  input  REG_ID_W  ALU destination register.
REQ-007 aluData_i  input  XLEN  ALU result.
REQ-008 aluReady_o  output  1  ALU writeback accepted this cycle.
REQ-009 lsuValid_i  input  1  load unit has a writeback pending.
REQ-010 lsuRdId_i  input  REG_ID_W  load destination register.
REQ-011 lsuData_i  input  XLEN  load data.
REQ-012 lsuReady_o  output  1  load writeback accepted this cycle.
REQ-013 issue_i  input  1  decode issues an instruction writing issueRdId_i.
REQ-014 issueRdId_i  input  REG_ID_W  destination of issued instruction.
REQ-015 rs1Id_i, rs2Id_i  input  REG_ID_W each  source registers of instruction in decode.
REQ-016 rs1Busy_o, rs2Busy_o  output  1 each  source has an outstanding, not-yet-committed write.
REQ-017 issueStall_o  output  1  issue blocked: source busy or destination already pending.
REQ-018 rdId_o  output  REG_ID_W  register file write index; 0 means no write.
REQ-019 rdData_o  output  XLEN  register file write data.

Function
REQ-020 Handshake: transfer occurs when valid and ready both high; requester SHALL hold id/data stable until transfer; ready is combinational from valids and arbitration state.
REQ-021 Only one requester SHALL be granted per cycle; single valid requester is granted immediately.
REQ-022 Both valid: round-robin; grant the requester not granted at the most recent contended cycle; lastGrant register updates only on contended cycles.
REQ-023 Accepted write SHALL appear on rdId_o/rdData_o exactly one cycle after transfer (registered); rdId_o=0, rdData_o=0 in cycles with no transfer.
REQ-024 Request with rdId 0 is accepted normally and produces rdId_o=0 (no write).
REQ-025 Scoreboard: one pending bit per register 1..2**REG_ID_W-1; bit 0 constant 0.
REQ-026 issue_i with issueStall_o low and issueRdId_i!=0 SHALL set the pending bit at the clock edge.
REQ-027 Pending bit for rdId_o SHALL clear at the edge ending the cycle rdId_o is driven (same edge the register file writes); busy therefore low two cycles after transfer.
REQ-028 Simultaneous clear and set of the same register: set wins, bit stays 1.
REQ-029 rsNBusy_o = pending[rsNId_i], combinational; no bypass of rdId_o.
REQ-030 issueStall_o = issue_i and (rs1Busy_o or rs2Busy_o or pending[issueRdId_i]); stalled issue SHALL not modify scoreboard.
REQ-031 Writeback to a non-pending register SHALL still be written; pending bit unaffected.

Reset
REQ-032 While reset_i high at an edge: all pending bits 0, rdId_o=0, rdData_o=0, lastGrant=LSU (so first contended grant goes to ALU).
REQ-033 Reset mid-operation SHALL drop any transfer in that cycle; ready outputs remain combinational but accepted data is discarded.

Structure
REQ-034 XLEN, REG_ID_W defaults and the grant encoding (GRANT_ALU, GRANT_LSU) SHALL live in shared package regfile_pkg.
REQ-035 Scoreboard SHALL be a sub-module wb_scoreboard (set, clear, two read ports, stall logic); arbitration and output register in top.

Verification
REQ-036 ALU only: aluValid=1, rd=5, data=0xDEADBEEF -> aluReady=1 same cycle, next cycle rdId_o=5, rdData_o=0xDEADBEEF.
REQ-037 Contention: both valid 4 cycles, ALU rd=3, LSU rd=4 -> grants ALU,LSU,ALU,LSU after reset; rdId_o 3,4,3,4 delayed one cycle.
REQ-038 Scoreboard: issue rd=7 cycle 0; rs1Id=7 -> rs1Busy=1 and issueStall=1 until LSU transfer rd=7 at cycle N; rs1Busy=0 at N+2.
REQ-039 Same-edge set/clear: rdId_o=9 while issue rd=9 with no stall (bit 9 previously cleared path disabled via forced scenario) -> pending[9]=1 after edge.
REQ-040 x0: issue rd=0 -> no pending set, issueStall=0; writeback rd=0 -> rdId_o=0.
REQ-041 Reset mid-operation: pending bits 2,3 set, both requesters valid, assert reset one cycle -> next cycle all busy 0, rdId_o=0, first contended grant ALU.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file writeback arbiter:
//   XLEN_DEF      default writeback data width
//   REG_ID_W_DEF  default register index width (2**REG_ID_W_DEF registers)
//   GRANT_ALU / GRANT_LSU  encoding of the round-robin "last contended grant"
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int REG_ID_W_DEF = 5;

  typedef logic [0:0] grant_t;

  localparam logic [0:0] GRANT_ALU = 1'b0;
  localparam logic [0:0] GRANT_LSU = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the writeback requesters, the decode/issue scoreboard port and the
// register-file write port of regfile_wb_arbiter.
//   slave  : arbiter side (consumes requests, drives ready/busy/stall/write)
//   master : environment side (drives requests and issue information)
// Signals:
//   aluValid_i/aluRdId_i/aluData_i/aluReady_o   ALU writeback channel
//   lsuValid_i/lsuRdId_i/lsuData_i/lsuReady_o   load-unit writeback channel
//   issue_i/issueRdId_i/rs1Id_i/rs2Id_i         decode-stage information
//   rs1Busy_o/rs2Busy_o/issueStall_o            hazard outputs
//   rdId_o/rdData_o                             register file write port
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_ID_W = REG_ID_W_DEF
) ();

  logic                aluValid_i;
  logic [REG_ID_W-1:0] aluRdId_i;
  logic [XLEN-1:0]     aluData_i;
  logic                aluReady_o;

  logic                lsuValid_i;
  logic [REG_ID_W-1:0] lsuRdId_i;
  logic [XLEN-1:0]     lsuData_i;
  logic                lsuReady_o;

  logic                issue_i;
  logic [REG_ID_W-1:0] issueRdId_i;
  logic [REG_ID_W-1:0] rs1Id_i;
  logic [REG_ID_W-1:0] rs2Id_i;
  logic                rs1Busy_o;
  logic                rs2Busy_o;
  logic                issueStall_o;

  logic [REG_ID_W-1:0] rdId_o;
  logic [XLEN-1:0]     rdData_o;

  modport slave (
    input  aluValid_i, aluRdId_i, aluData_i,
    output aluReady_o,
    input  lsuValid_i, lsuRdId_i, lsuData_i,
    output lsuReady_o,
    input  issue_i, issueRdId_i, rs1Id_i, rs2Id_i,
    output rs1Busy_o, rs2Busy_o, issueStall_o,
    output rdId_o, rdData_o
  );

  modport master (
    output aluValid_i, aluRdId_i, aluData_i,
    input  aluReady_o,
    output lsuValid_i, lsuRdId_i, lsuData_i,
    input  lsuReady_o,
    output issue_i, issueRdId_i, rs1Id_i, rs2Id_i,
    input  rs1Busy_o, rs2Busy_o, issueStall_o,
    input  rdId_o, rdData_o
  );

endinterface

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// One pending bit per architectural register (x0 is never pending).
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   issue_i             decode issues an instruction writing issue_rd_id_i
//   issue_rd_id_i       destination of the issued instruction
//   clr_id_i            register currently being written (0 = none)
//   rs1_id_i, rs2_id_i  source registers in decode
//   rs1_busy_o, rs2_busy_o  source has an outstanding write
//   issue_stall_o       issue blocked by a busy source or pending destination
// -----------------------------------------------------------------------------
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_ID_W = REG_ID_W_DEF
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                issue_i,
  input  logic [REG_ID_W-1:0] issue_rd_id_i,
  input  logic [REG_ID_W-1:0] clr_id_i,
  input  logic [REG_ID_W-1:0] rs1_id_i,
  input  logic [REG_ID_W-1:0] rs2_id_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  output logic                issue_stall_o
);

  localparam int NREG = 1 << REG_ID_W;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic            set_en;

  // Plain lookups: the write on rdId_o is not bypassed, so a source stays busy
  // through the cycle its value is being written.
  assign rs1_busy_o    = pending_q[rs1_id_i];
  assign rs2_busy_o    = pending_q[rs2_id_i];
  assign issue_stall_o = issue_i &
                         (rs1_busy_o | rs2_busy_o | pending_q[issue_rd_id_i]);
  assign set_en        = issue_i & ~issue_stall_o & (issue_rd_id_i != '0);

  // Clear first, then set, so a same-edge set of the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_id_i != '0) pending_d[clr_id_i] = 1'b0;
    if (set_en)         pending_d[issue_rd_id_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) pending_q <= '0;
    else         pending_q <= pending_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates ALU and load-unit writebacks onto a single registered register
// file write port and tracks outstanding writes for decode hazard detection.
// Ports:
//   clk_i             clock
//   reset_i           synchronous active-high reset
//   bus               regfile_wb_arbiter_if.slave (requesters, issue, write port)
//   dbg_last_grant_o  arbitration state: winner of the last contended cycle
//
// Handshake: a writeback transfers in a cycle where its valid and ready are
// both high. The requester holds id/data stable until then. Ready is a purely
// combinational function of both valids and the last contended grant; at most
// one ready is high per cycle. A transfer in a reset cycle is discarded.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_ID_W = REG_ID_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  regfile_wb_arbiter_if.slave  bus,
  output logic                 dbg_last_grant_o
);

  logic [0:0]          last_grant_q;
  logic [0:0]          last_grant_d;
  logic [REG_ID_W-1:0] rd_id_q;
  logic [REG_ID_W-1:0] rd_id_d;
  logic [XLEN-1:0]     rd_data_q;
  logic [XLEN-1:0]     rd_data_d;
  logic                alu_ready;
  logic                lsu_ready;
  logic                contended;

  assign contended = bus.aluValid_i & bus.lsuValid_i;

  // Under contention the requester that lost the previous contended cycle wins.
  assign alu_ready = bus.aluValid_i & (~bus.lsuValid_i | (last_grant_q == GRANT_LSU));
  assign lsu_ready = bus.lsuValid_i & (~bus.aluValid_i | (last_grant_q == GRANT_ALU));

  assign bus.aluReady_o = alu_ready;
  assign bus.lsuReady_o = lsu_ready;

  always_comb begin
    rd_id_d      = '0;
    rd_data_d    = '0;
    last_grant_d = last_grant_q;
    if (alu_ready) begin
      rd_id_d   = bus.aluRdId_i;
      rd_data_d = bus.aluData_i;
    end else if (lsu_ready) begin
      rd_id_d   = bus.lsuRdId_i;
      rd_data_d = bus.lsuData_i;
    end
    // Uncontended grants leave the round-robin pointer alone.
    if (contended) last_grant_d = alu_ready ? GRANT_ALU : GRANT_LSU;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_id_q      <= '0;
      rd_data_q    <= '0;
      last_grant_q <= GRANT_LSU;
    end else begin
      rd_id_q      <= rd_id_d;
      rd_data_q    <= rd_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rdId_o      = rd_id_q;
  assign bus.rdData_o    = rd_data_q;
  assign dbg_last_grant_o = last_grant_q[0];

  // The pending bit clears on the same edge the register file consumes rdId_o.
  wb_scoreboard #(.REG_ID_W(REG_ID_W)) u_scoreboard (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .issue_i       (bus.issue_i),
    .issue_rd_id_i (bus.issueRdId_i),
    .clr_id_i      (rd_id_q),
    .rs1_id_i      (bus.rs1Id_i),
    .rs2_id_i      (bus.rs2Id_i),
    .rs1_busy_o    (bus.rs1Busy_o),
    .rs2_busy_o    (bus.rs2Busy_o),
    .issue_stall_o (bus.issueStall_o)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed scenarios followed by randomized held requests. Each driven cycle
// the reference model predicts ready/busy/stall (checked in-cycle) and the
// write-port value for the next cycle (pushed to exp_q, checked by the monitor).
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int XW   = 32;
  localparam int RW   = 5;
  localparam int NREG = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dbg_last_grant;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XW), .REG_ID_W(RW)) bus ();

  regfile_wb_arbiter #(.XLEN(XW), .REG_ID_W(RW)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .bus              (bus),
    .dbg_last_grant_o (dbg_last_grant)
  );

  // ---------------- reference model state ----------------
  // Winner codes used by the model only: 0 none, 1 ALU, 2 LSU.
  bit          pend[NREG];
  int          last_win = 2;
  bit          model_ok = 1'b0;
  logic [RW-1:0] out_rd = '0;   // register being written on the port this cycle

  // Expected port value: {check_data, rd, data}
  logic [XW+RW:0] exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver + model ----------------
  task automatic step(input bit rst,
                      input bit av, input logic [RW-1:0] ard, input logic [XW-1:0] ad,
                      input bit lv, input logic [RW-1:0] lrd, input logic [XW-1:0] ld,
                      input bit iss, input logic [RW-1:0] ird,
                      input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                      output bit alu_took, output bit lsu_took);
    int win;
    bit e_stall;
    @(negedge clk);
    reset            = rst;
    bus.aluValid_i   = av;  bus.aluRdId_i = ard; bus.aluData_i = ad;
    bus.lsuValid_i   = lv;  bus.lsuRdId_i = lrd; bus.lsuData_i = ld;
    bus.issue_i      = iss; bus.issueRdId_i = ird;
    bus.rs1Id_i      = r1;  bus.rs2Id_i = r2;
    #1;
    if (av && lv)  win = (last_win == 2) ? 1 : 2;
    else if (av)   win = 1;
    else if (lv)   win = 2;
    else           win = 0;
    e_stall = iss && (pend[r1] || pend[r2] || pend[ird]);
    if (model_ok) begin
      check("aluReady",   bus.aluReady_o,   win == 1);
      check("lsuReady",   bus.lsuReady_o,   win == 2);
      check("rs1Busy",    bus.rs1Busy_o,    pend[r1]);
      check("rs2Busy",    bus.rs2Busy_o,    pend[r2]);
      check("issueStall", bus.issueStall_o, e_stall);
    end
    alu_took = (win == 1);
    lsu_took = (win == 2);
    if (rst) begin
      foreach (pend[i]) pend[i] = 1'b0;
      last_win = 2;
      model_ok = 1'b1;
      out_rd   = '0;
      exp_q.push_back({1'b1, {RW{1'b0}}, {XW{1'b0}}});
    end else begin
      if (av && lv) last_win = win;
      // The register on the port is written at this edge, so it stops being
      // pending; a simultaneous new issue to it takes priority.
      if (out_rd != 0) pend[out_rd] = 1'b0;
      if (iss && !e_stall && ird != 0) pend[ird] = 1'b1;
      if (win == 1) begin
        exp_q.push_back({(ard != 0), ard, ad});
        out_rd = ard;
      end else if (win == 2) begin
        exp_q.push_back({(lrd != 0), lrd, ld});
        out_rd = lrd;
      end else begin
        exp_q.push_back({1'b1, {RW{1'b0}}, {XW{1'b0}}});
        out_rd = '0;
      end
    end
  endtask

  task automatic idle(input logic [RW-1:0] r1, input logic [RW-1:0] r2);
    bit a, l;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, a, l);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [XW+RW:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rdId_o", bus.rdId_o, e[XW+RW-1:XW]);
        if (e[XW+RW]) check("rdData_o", bus.rdData_o, e[XW-1:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit at, lt;
    bit a_v, l_v;
    logic [RW-1:0] a_rd, l_rd;
    logic [XW-1:0] a_d, l_d;

    // reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, at, lt);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, at, lt);

    // ALU alone
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, at, lt);
    idle(5, 0);

    // Contention: expect ALU, LSU, ALU, LSU
    repeat (4) step(0, 1, 3, 32'h3333_0003, 1, 4, 32'h4444_0004, 0, 0, 0, 0, at, lt);
    idle(0, 0);

    // Scoreboard: issue x7, dependent stalls until the load writes x7
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, at, lt);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 10, 7, 0, at, lt);
    step(0, 0, 0, 0, 1, 7, 32'h7777_7777, 1, 10, 7, 0, at, lt);
    step(0, 0, 0, 0, 0, 0, 0, 1, 10, 7, 0, at, lt);
    step(0, 0, 0, 0, 0, 0, 0, 1, 10, 7, 0, at, lt);
    idle(7, 10);

    // Same-edge set/clear on x9
    step(0, 0, 0, 0, 1, 9, 32'h9999_0009, 0, 0, 0, 0, at, lt);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, at, lt);
    idle(9, 0);
    step(0, 1, 9, 32'h0000_0099, 0, 0, 0, 0, 0, 9, 0, at, lt);
    idle(9, 10);
    idle(9, 10);

    // x0: never pending, writes produce rdId_o = 0
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, at, lt);
    step(0, 1, 0, 32'h0000_1234, 0, 0, 0, 1, 0, 0, 0, at, lt);
    idle(0, 0);

    // Reset mid-operation
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, at, lt);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, at, lt);
    step(0, 1, 11, 32'hB0B0_0011, 1, 12, 32'hC0C0_0012, 0, 0, 2, 3, at, lt);
    step(1, 1, 13, 32'hB0B0_0013, 1, 12, 32'hC0C0_0012, 0, 0, 2, 3, at, lt);
    step(0, 1, 13, 32'hB0B0_0013, 1, 12, 32'hC0C0_0012, 0, 0, 2, 3, at, lt);
    idle(2, 3);

    // Randomized held requests with occasional reset
    a_v = 0; l_v = 0; a_rd = '0; l_rd = '0; a_d = '0; l_d = '0;
    repeat (600) begin
      if (!a_v && $urandom_range(0, 2) != 0) begin
        a_v = 1; a_rd = RW'($urandom_range(0, 7)); a_d = $urandom;
      end
      if (!l_v && $urandom_range(0, 2) != 0) begin
        l_v = 1; l_rd = RW'($urandom_range(0, 7)); l_d = $urandom;
      end
      step(($urandom_range(0, 99) == 0), a_v, a_rd, a_d, l_v, l_rd, l_d,
           ($urandom_range(0, 1) == 1), RW'($urandom_range(0, 7)),
           RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)), at, lt);
      if (at) a_v = 0;
      if (lt) l_v = 0;
    end
    idle(0, 0);

    @(posedge clk);
    #3;
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
